ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles for stalls and branch/jump flushes.
- Sits beside the datapath pipeline registers; the datapath consumes each stage's control outputs directly.

Parameters:
- ALUOP_W, 4, ALUOp field width; must be >= 4; codes below are zero-extended.
- REG_AW, 5, register-address width for hazard comparison.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_op  in  6  opcode of ID-stage instruction
- id_rs  in  REG_AW  rs field of ID-stage instruction
- id_rt  in  REG_AW  rt field of ID-stage instruction
- ex_flush  in  1  branch/jump taken, resolved in EX; kill the ID-stage instruction
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid, ex_regdst, ex_alusrc, ex_branch, ex_jump  out  1 each  EX-stage controls
- ex_aluop  out  ALUOP_W  EX-stage ALU operation
- ex_illegal  out  1  EX-stage instruction had an undecoded opcode
- mem_valid, mem_memread, mem_memwrite  out  1 each  MEM-stage controls
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls

Behaviour:
- Decode table (combinational, ID stage). Bit order: RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, Jump, then ALUOp.
  - 000000 R-type: 11000000, ALUOp 2
  - 000010 j: 00000001, ALUOp 0
  - 000100 beq: 00010000, ALUOp 1
  - 000101 bne: 00010000, ALUOp 3
  - 001000 addi: 01100000, ALUOp 4
  - 001100 andi: 01100000, ALUOp 5
  - 001001 addiu: 01100000, ALUOp 6
  - 001010 slti: 01100000, ALUOp 7
  - 001101 ori: 01100000, ALUOp 8
  - 100011 lw: 01101010, ALUOp 4
  - 101011 sw: 00100100, ALUOp 4
  - 000011 jal: 01000001, ALUOp 0
  - Any other opcode: all zero, with illegal=1.
- uses_rt is 1 for R-type, beq, bne and sw.
- hazard_stall = id_valid & ex_valid & ex_memread_int & (ex_rt_q != 0) & ((ex_rt_q == id_rs) | (uses_rt & ex_rt_q == id_rt)) & ~ex_flush.
  - ex_memread_int is the internal ID/EX MemRead bit.
  - ex_rt_q is id_rt as captured into ID/EX.
- ID/EX load each cycle:
  - If ex_flush, hazard_stall or ~id_valid: load a bubble (all controls 0, valid 0, illegal 0).
  - Otherwise: load the decoded bundle with valid=1, and capture id_rt into ex_rt_q.
  - Flush has priority over stall.
- EX/MEM and MEM/WB advance every cycle unconditionally.
  - A bubble propagates as valid=0 with all-zero controls.
  - Every stage output is gated: a stage with valid=0 never asserts regwrite, memwrite or memread.
- Latency: the ID decode appears on ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later.
- Reset: while rst_n=0 at a clock edge, every pipeline register clears to 0, so every registered output is 0 after the edge.
  - hazard_stall reads 0 after reset because ex_valid=0.
  - Reset mid-stream discards all in-flight control.
- Back-to-back loads: lw followed by a dependent lw stalls exactly 1 cycle.
- An rt match against register 0 never stalls.
- A stall never repeats for the same pair: after the bubble, ex_valid=0.

Optional Feature:
- Macro: CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt (32) and perf_flush_cnt (32), both reset to 0.
  - perf_stall_cnt increments on each cycle with hazard_stall=1.
  - perf_flush_cnt increments on each cycle with ex_flush=1 & id_valid=1.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then id_valid=1, id_op=100011 (lw) for 1 cycle:
   - next cycle: ex_alusrc=1, ex_aluop=4, ex_valid=1
   - +1 cycle: mem_memread=1
   - +2 cycles: wb_regwrite=1 and wb_memtoreg=1
2. lw with rt=5, followed by R-type with rs=5:
   - hazard_stall=1 for exactly 1 cycle; ex_valid=0 on the next cycle.
   - The R-type then enters EX with ex_regdst=1 and ex_aluop=2.
3. lw with rt=0, followed by R-type with rs=0: hazard_stall stays 0.
   - lw with rt=7, followed by addi with rt=7 (addi does not use rt): no stall.
4. Stall condition and ex_flush=1 in the same cycle: hazard_stall=0 and ID/EX receives a bubble (ex_valid=0, all ex_* = 0).
5. id_op=111111 with id_valid=1: next cycle ex_illegal=1, all other controls 0, and no regwrite/memwrite ever appears downstream.
6. rst_n=0 with all three stages valid: after the edge, all outputs are 0.
   - With CTRL_PERF_EN defined: 3 stalls and 2 flushes give counter values 3 and 2.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main control unit.
// Decodes the ID-stage opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB registers, with load-use stall detection and bubble
// insertion for stalls and EX-resolved branch/jump flushes.
// Optional macro CTRL_PERF_EN adds saturating stall/flush event counters.
module ctrl_pipe #(
    parameter int ALUOP_W = 4,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [5:0]         id_op,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               ex_flush,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_illegal,
    output logic               mem_valid,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_memtoreg
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Control vector bit positions, MSB first:
    // RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, Jump
    localparam int C_REGDST   = 7;
    localparam int C_REGWRITE = 6;
    localparam int C_ALUSRC   = 5;
    localparam int C_BRANCH   = 4;
    localparam int C_MEMREAD  = 3;
    localparam int C_MEMWRITE = 2;
    localparam int C_MEMTOREG = 1;
    localparam int C_JUMP     = 0;

    logic [7:0]         dec_ctl;
    logic [3:0]         dec_code;
    logic               dec_illegal;
    logic               dec_uses_rt;

    logic               ex_valid_reg;
    logic [7:0]         ex_ctl_reg;
    logic [ALUOP_W-1:0] ex_aluop_reg;
    logic               ex_illegal_reg;
    logic [REG_AW-1:0]  ex_rt_reg;
    logic [7:0]         ex_ctl_gated;

    logic               mem_valid_reg;
    logic               mem_memread_reg;
    logic               mem_memwrite_reg;
    logic               mem_regwrite_reg;
    logic               mem_memtoreg_reg;

    logic               wb_valid_reg;
    logic               wb_regwrite_reg;
    logic               wb_memtoreg_reg;

    logic               load_bubble;

    // ID-stage opcode decode into control bits, ALUOp code and rt usage
    always_comb begin
        dec_ctl     = 8'b0000_0000;
        dec_code    = 4'd0;
        dec_illegal = 1'b0;
        dec_uses_rt = 1'b0;
        case (id_op)
            OP_RTYPE: begin dec_ctl = 8'b1100_0000; dec_code = 4'd2; dec_uses_rt = 1'b1; end
            OP_J:     begin dec_ctl = 8'b0000_0001; dec_code = 4'd0; end
            OP_BEQ:   begin dec_ctl = 8'b0001_0000; dec_code = 4'd1; dec_uses_rt = 1'b1; end
            OP_BNE:   begin dec_ctl = 8'b0001_0000; dec_code = 4'd3; dec_uses_rt = 1'b1; end
            OP_ADDI:  begin dec_ctl = 8'b0110_0000; dec_code = 4'd4; end
            OP_ANDI:  begin dec_ctl = 8'b0110_0000; dec_code = 4'd5; end
            OP_ADDIU: begin dec_ctl = 8'b0110_0000; dec_code = 4'd6; end
            OP_SLTI:  begin dec_ctl = 8'b0110_0000; dec_code = 4'd7; end
            OP_ORI:   begin dec_ctl = 8'b0110_0000; dec_code = 4'd8; end
            OP_LW:    begin dec_ctl = 8'b0110_1010; dec_code = 4'd4; end
            OP_SW:    begin dec_ctl = 8'b0010_0100; dec_code = 4'd4; dec_uses_rt = 1'b1; end
            OP_JAL:   begin dec_ctl = 8'b0100_0001; dec_code = 4'd0; end
            default:  begin dec_illegal = 1'b1; end
        endcase
    end

    // Load-use hazard: a load in EX whose destination (rt) feeds the ID instruction.
    // A taken flush kills the ID instruction anyway, so it suppresses the stall.
    always_comb begin
        hazard_stall = id_valid & ex_valid_reg & ex_ctl_reg[C_MEMREAD]
                     & (ex_rt_reg != '0)
                     & ((ex_rt_reg == id_rs) | (dec_uses_rt & (ex_rt_reg == id_rt)))
                     & ~ex_flush;
    end

    assign load_bubble = ex_flush | hazard_stall | ~id_valid;

    // ID/EX register: decoded bundle or a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_ctl_reg     <= '0;
            ex_aluop_reg   <= '0;
            ex_illegal_reg <= 1'b0;
            ex_rt_reg      <= '0;
        end else if (load_bubble) begin
            ex_valid_reg   <= 1'b0;
            ex_ctl_reg     <= '0;
            ex_aluop_reg   <= '0;
            ex_illegal_reg <= 1'b0;
            ex_rt_reg      <= '0;
        end else begin
            ex_valid_reg   <= 1'b1;
            ex_ctl_reg     <= dec_ctl;
            ex_aluop_reg   <= ALUOP_W'(dec_code);
            ex_illegal_reg <= dec_illegal;
            ex_rt_reg      <= id_rt;
        end
    end

    // A stage that holds no instruction never drives any control high
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ex_gate
            assign ex_ctl_gated[gi] = ex_ctl_reg[gi] & ex_valid_reg;
        end
    endgenerate

    // EX/MEM register: advances every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid_reg    <= 1'b0;
            mem_memread_reg  <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_regwrite_reg <= 1'b0;
            mem_memtoreg_reg <= 1'b0;
        end else begin
            mem_valid_reg    <= ex_valid_reg;
            mem_memread_reg  <= ex_ctl_gated[C_MEMREAD];
            mem_memwrite_reg <= ex_ctl_gated[C_MEMWRITE];
            mem_regwrite_reg <= ex_ctl_gated[C_REGWRITE];
            mem_memtoreg_reg <= ex_ctl_gated[C_MEMTOREG];
        end
    end

    // MEM/WB register: advances every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_reg    <= 1'b0;
            wb_regwrite_reg <= 1'b0;
            wb_memtoreg_reg <= 1'b0;
        end else begin
            wb_valid_reg    <= mem_valid_reg;
            wb_regwrite_reg <= mem_regwrite_reg & mem_valid_reg;
            wb_memtoreg_reg <= mem_memtoreg_reg & mem_valid_reg;
        end
    end

    assign ex_valid     = ex_valid_reg;
    assign ex_regdst    = ex_ctl_gated[C_REGDST];
    assign ex_alusrc    = ex_ctl_gated[C_ALUSRC];
    assign ex_branch    = ex_ctl_gated[C_BRANCH];
    assign ex_jump      = ex_ctl_gated[C_JUMP];
    assign ex_aluop     = ex_aluop_reg & {ALUOP_W{ex_valid_reg}};
    assign ex_illegal   = ex_illegal_reg & ex_valid_reg;
    assign mem_valid    = mem_valid_reg;
    assign mem_memread  = mem_memread_reg & mem_valid_reg;
    assign mem_memwrite = mem_memwrite_reg & mem_valid_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_regwrite  = wb_regwrite_reg & wb_valid_reg;
    assign wb_memtoreg  = wb_memtoreg_reg & wb_valid_reg;

`ifdef CTRL_PERF_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hazard_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ex_flush && id_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
